// File: rtl/axil_seq_master.sv
// axil_seq_master -- AXI-Lite master sequencer.
//
// Takes a stream of commands (write / read / poll-until-match), runs each one
// on the AXI-Lite bus, and returns exactly one response per command. Only one
// bus transaction is outstanding at a time.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET   clock, synchronous active-high reset
//   cmd_valid/ready            command handshake
//   cmd_op                     00 write, 01 read, 10 poll, 11 read
//   cmd_addr                   register offset (BASE is added)
//   cmd_data                   write data / poll expected value
//   cmd_mask                   poll compare mask; bit 8*i drives WSTRB[i]
//   rsp_valid/ready            response handshake
//   rsp_data                   read data (last read for poll, 0 for write)
//   rsp_status                 00 OK, 01 bus error, 10 poll timeout
//   M_AXI_*                    AXI-Lite master channels (AW, W, B, AR, R)
//
// Optional build macro AXIL_SEQ_STATS_EN adds the 32-bit saturating counters
// stat_wr_cnt, stat_rd_cnt and stat_err_cnt.

module axil_seq_master #(
  parameter int          C_M_AXI_ADDR_WIDTH         = 4,
  parameter int          C_M_AXI_DATA_WIDTH         = 32,
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0,
  parameter int          POLL_MAX                   = 1024,
  parameter int          POLL_GAP                   = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_mask,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                      rsp_status,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
`ifdef AXIL_SEQ_STATS_EN
  ,
  output logic [31:0]                     stat_wr_cnt,
  output logic [31:0]                     stat_rd_cnt,
  output logic [31:0]                     stat_err_cnt
`endif
);

  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int DW     = C_M_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int PCNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  localparam logic [AW-1:0]     BASE_C     = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [PCNT_W-1:0] POLL_MAX_C = PCNT_W'(POLL_MAX);
  localparam logic [GAP_W-1:0]  GAP_LAST_C = GAP_W'(GAP_LAST);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  if (DW != 32 && DW != 64) begin : g_bad_dw
    $error("C_M_AXI_DATA_WIDTH must be 32 or 64");
  end
  if (POLL_MAX < 1) begin : g_bad_pmax
    $error("POLL_MAX must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_RESP, S_GAP, S_RSP
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [DW-1:0]     mask_q, mask_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              cmd_ready_q, rsp_valid_q;

  logic poll_match;
  assign poll_match = ((M_AXI_RDATA ^ data_q) & mask_q) == '0;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    poll_cnt_d   = poll_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d         = cmd_op;
          addr_d       = cmd_addr + BASE_C;
          data_d       = cmd_data;
          mask_d       = cmd_mask;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          poll_cnt_d   = '0;
          if (cmd_op == OP_WR) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR: begin
        // AW and W complete independently, in either order
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_d      = S_RSP;
          rsp_status_d = (M_AXI_BRESP != 2'b00) ? ST_ERR : ST_OK;
        end
      end
      S_RD: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_RESP;
          if (poll_cnt_q != POLL_MAX_C) poll_cnt_d = poll_cnt_q + PCNT_W'(1);
        end
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rsp_data_d = M_AXI_RDATA;
          if (op_q != OP_POLL) begin
            state_d      = S_RSP;
            rsp_status_d = (M_AXI_RRESP != 2'b00) ? ST_ERR : ST_OK;
          end else if (M_AXI_RRESP != 2'b00) begin
            state_d      = S_RSP;
            rsp_status_d = ST_ERR;
          end else if (poll_match) begin
            state_d      = S_RSP;
            rsp_status_d = ST_OK;
          end else if (poll_cnt_q == POLL_MAX_C) begin
            state_d      = S_RSP;
            rsp_status_d = ST_TMO;
          end else if (POLL_GAP == 0) begin
            state_d   = S_RD;
            arvalid_d = 1'b1;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST_C) begin
          state_d   = S_RD;
          arvalid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q      <= S_IDLE;
      op_q         <= 2'b00;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'b00;
      poll_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      poll_cnt_q   <= poll_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      // handshake flags follow the next state so they are never high together
      cmd_ready_q  <= (state_d == S_IDLE);
      rsp_valid_q  <= (state_d == S_RSP);
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_status    = rsp_status_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == S_RD_RESP);

  for (genvar i = 0; i < STRB_W; i++) begin : g_strb
    assign M_AXI_WSTRB[i] = mask_q[8*i];
  end

`ifdef AXIL_SEQ_STATS_EN
  logic [31:0] st_wr_q, st_rd_q, st_err_q;
  logic        b_hs, r_hs, err_ev;

  assign b_hs   = M_AXI_BVALID && (state_q == S_WR_RESP);
  assign r_hs   = M_AXI_RVALID && (state_q == S_RD_RESP);
  assign err_ev = (state_q != S_RSP) && (state_d == S_RSP) && (rsp_status_d != ST_OK);

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      st_wr_q  <= '0;
      st_rd_q  <= '0;
      st_err_q <= '0;
    end else begin
      if (b_hs   && st_wr_q  != 32'hFFFF_FFFF) st_wr_q  <= st_wr_q  + 32'd1;
      if (r_hs   && st_rd_q  != 32'hFFFF_FFFF) st_rd_q  <= st_rd_q  + 32'd1;
      if (err_ev && st_err_q != 32'hFFFF_FFFF) st_err_q <= st_err_q + 32'd1;
    end
  end

  assign stat_wr_cnt  = st_wr_q;
  assign stat_rd_cnt  = st_rd_q;
  assign stat_err_cnt = st_err_q;
`endif

endmodule

// File: tb/tb_axil_seq_master.sv
// Self-checking bench for axil_seq_master (POLL_MAX=8, POLL_GAP=4).
// A small AXI-Lite slave answers the bus; a response model predicts each
// command's outcome from the command and the slave's read data.

module tb_axil_seq_master;

  localparam int PMAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]  cmd_op, rsp_status;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_data, cmd_mask, rsp_data;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
`ifdef AXIL_SEQ_STATS_EN
  logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

  always #5 clk = ~clk;

  axil_seq_master #(.POLL_MAX(PMAX), .POLL_GAP(4)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
`ifdef AXIL_SEQ_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
    .stat_err_cnt(stat_err_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // ---------------- slave ----------------
  int          aw_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rd_q[$];
  int          aw_wait;
  logic        aw_got, w_got, ar_got;
  int          aw_hi_n = 0, w_hi_n = 0, b_hs_n = 0, ar_hs_n = 0;
  logic [3:0]  last_awaddr, last_araddr, last_wstrb;
  logic [31:0] last_wdata;
  int          ar_t[$];

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = 1'b1;
  assign arready = 1'b1;

  // Write response is raised the cycle after both AW and W have been taken;
  // read data the cycle after AR has been taken.
  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00;
      rdata <= '0;
    end else begin
      if (awvalid) aw_hi_n <= aw_hi_n + 1;
      if (wvalid)  w_hi_n  <= w_hi_n + 1;
      if (awvalid && awready) begin
        aw_got <= 1'b1; aw_wait <= 0; last_awaddr <= awaddr;
      end else if (awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1; last_wdata <= wdata; last_wstrb <= wstrb;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_hs_n <= b_hs_n + 1;
      end
      if (arvalid && arready) begin
        ar_got <= 1'b1; last_araddr <= araddr; ar_hs_n <= ar_hs_n + 1;
        ar_t.push_back(cyc);
      end
      if (ar_got && !rvalid) begin
        rvalid <= 1'b1; rresp <= rresp_cfg; ar_got <= 1'b0;
        if (rd_q.size() > 0) rdata <= rd_q.pop_front();
        else rdata <= '0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- response model ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  status;
    int          reads;
    int          ar0;
  } rsp_t;
  rsp_t exp_q[$];

  function automatic rsp_t model(input logic [1:0] op, input logic [31:0] d,
                                 input logic [31:0] m);
    rsp_t r;
    logic [31:0] v;
    r.ar0 = 0;
    if (op == 2'b00) begin
      r.data = 0; r.reads = 0;
      r.status = (bresp_cfg != 0) ? 2'b01 : 2'b00;
      return r;
    end
    if (op != 2'b10) begin
      r.data = (rd_q.size() > 0) ? rd_q[0] : 32'h0; r.reads = 1;
      r.status = (rresp_cfg != 0) ? 2'b01 : 2'b00;
      return r;
    end
    r.data = 0; r.reads = 0; r.status = 2'b10;
    for (int i = 0; i < PMAX; i++) begin
      v = (i < rd_q.size()) ? rd_q[i] : 32'h0;
      r.data = v; r.reads = i + 1;
      if (rresp_cfg != 0) begin r.status = 2'b01; return r; end
      if ((v & m) == (d & m)) begin r.status = 2'b00; return r; end
    end
    return r;
  endfunction

  // ---------------- compare process ----------------
  logic       chk_en = 1'b0;
  logic       p_rst = 1'b1, p_aw = 1'b0, p_ar = 1'b0, p_w = 1'b0;
  logic [3:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (rsp_valid) begin
        chk("rsp_excl_cmd_ready", cmd_ready, 1'b0);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_rsp: got data %0h status %0h, no command pending",
                   rsp_data, rsp_status);
        end else begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_status", rsp_status, exp_q[0].status);
          if (rsp_ready) begin
            chk("reads_issued", ar_hs_n - exp_q[0].ar0, exp_q[0].reads);
            void'(exp_q.pop_front());
          end
        end
      end
      if (!p_rst) begin
        if (p_aw) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (p_ar) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
        if (p_w)  chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
      end
    end
    p_rst    = rst;
    p_aw     = awvalid && !awready;
    p_ar     = arvalid && !arready;
    p_w      = wvalid && !wready;
    p_awaddr = awaddr;
    p_araddr = araddr;
    p_wdata  = wdata;
  end

  // ---------------- stimulus ----------------
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a,
                         input logic [31:0] d, input logic [31:0] m,
                         input int hold, output int lat,
                         output logic [31:0] gd, output logic [1:0] gs);
    rsp_t e;
    int t, acc;
    e = model(op, d, m);
    e.ar0 = ar_hs_n;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    t = 0;
    while (!cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) fail_now("cmd_accept");
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) fail_now("rsp_wait");
    lat = cyc - acc;
    gd = rsp_data; gs = rsp_status;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("cmd_ready_held_off", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  int lat, b0, a0, w0, n0, t;
  logic [31:0] gd;
  logic [1:0]  gs;
`ifdef AXIL_SEQ_STATS_EN
  logic [31:0] e0;
`endif

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_handshakes", {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 7'b0);
    chk("reset_rsp", {rsp_data, rsp_status}, 34'h0);
    chk("reset_addr_data", {awaddr, araddr, wdata, wstrb, awprot, arprot}, 50'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);
    chk_en = 1'b1;

    // plain write, zero-wait slave
    b0 = b_hs_n;
    run_cmd(2'b00, 4'h4, 32'h0000_0002, 32'hFFFF_FFFF, 0, lat, gd, gs);
    chk("wr_latency", lat, 4);
    chk("wr_awaddr", last_awaddr, 4'h4);
    chk("wr_wstrb", last_wstrb, 4'hF);
    chk("wr_wdata", last_wdata, 32'h2);
    chk("wr_b_count", b_hs_n - b0, 1);
    chk("wr_rsp_lit", {gd, gs}, 34'h0);

    // AWREADY delayed 3 cycles
    aw_delay = 3; a0 = aw_hi_n; w0 = w_hi_n; b0 = b_hs_n;
    run_cmd(2'b00, 4'h4, 32'h0000_0055, 32'hFFFF_FFFF, 0, lat, gd, gs);
    chk("slow_aw_cycles", aw_hi_n - a0, 4);
    chk("slow_w_cycles", w_hi_n - w0, 1);
    chk("slow_b_count", b_hs_n - b0, 1);
    chk("slow_status", gs, 2'b00);
    aw_delay = 0;

    // partial strobes, slave error on B
    bresp_cfg = 2'b10;
    run_cmd(2'b00, 4'h0, 32'h0000_CAFE, 32'h00FF_00FF, 0, lat, gd, gs);
    chk("strb_partial", last_wstrb, 4'h5);
    chk("wr_err_status", gs, 2'b01);
    bresp_cfg = 2'b00;

    // read with error response, response held for 2 cycles
`ifdef AXIL_SEQ_STATS_EN
    e0 = stat_err_cnt;
`endif
    rd_q.push_back(32'hDEAD_BEEF); rresp_cfg = 2'b10;
    run_cmd(2'b01, 4'h8, 32'h0, 32'h0, 2, lat, gd, gs);
    chk("rd_latency", lat, 4);
    chk("rd_araddr", last_araddr, 4'h8);
    chk("rd_err_lit", {gd, gs}, {32'hDEAD_BEEF, 2'b01});
    rresp_cfg = 2'b00;
`ifdef AXIL_SEQ_STATS_EN
    chk("stat_err_delta", stat_err_cnt - e0, 32'd1);
`endif

    // reserved op behaves as a read
    rd_q.push_back(32'h1234_5678);
    run_cmd(2'b11, 4'h0, 32'h0, 32'h0, 0, lat, gd, gs);
    chk("op11_lit", {gd, gs}, {32'h1234_5678, 2'b00});

    // poll until bit 0 set: 0, 0, 1
    rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h1);
    n0 = ar_t.size();
    run_cmd(2'b10, 4'hC, 32'h1, 32'h1, 0, lat, gd, gs);
    chk("poll_ar_count", ar_t.size() - n0, 3);
    if (ar_t.size() - n0 == 3)
      for (int i = 0; i < 2; i++)
        chk("poll_gap_ge4", (ar_t[n0+i+1] - ar_t[n0+i] - 1) >= 4, 1'b1);
    chk("poll_lit", {gd, gs}, {32'h1, 2'b00});

    // poll timeout: slave always returns 0, response held 4 cycles
    n0 = ar_t.size();
    run_cmd(2'b10, 4'hC, 32'h1, 32'h1, 4, lat, gd, gs);
    chk("tmo_ar_count", ar_t.size() - n0, PMAX);
    chk("tmo_lit", {gd, gs}, {32'h0, 2'b10});

    // masked poll matches on the second read
    rd_q.push_back(32'h5A); rd_q.push_back(32'hA5);
    run_cmd(2'b10, 4'h4, 32'hA0, 32'hF0, 0, lat, gd, gs);
    chk("mpoll_lit", {gd, gs}, {32'hA5, 2'b00});

    // poll stops on a bus error
    rd_q.push_back(32'h7); rresp_cfg = 2'b01;
    run_cmd(2'b10, 4'h4, 32'h1, 32'h1, 0, lat, gd, gs);
    chk("epoll_lit", {gd, gs}, {32'h7, 2'b01});
    rresp_cfg = 2'b00;

    // reset while waiting for B: transaction abandoned, no response
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'h4;
    cmd_data = 32'h9; cmd_mask = 32'hFFFF_FFFF;
    t = 0;
    while (!cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) fail_now("rst_cmd_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (!bready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) fail_now("rst_wait_wr_resp");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outputs", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 7'b0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_valid, 1'b0);
    b0 = b_hs_n;
    run_cmd(2'b00, 4'h8, 32'h3, 32'hFFFF_FFFF, 0, lat, gd, gs);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_lit", {gd, gs}, 34'h0);
    chk("post_rst_b", b_hs_n - b0, 1);
`ifdef AXIL_SEQ_STATS_EN
    chk("stat_wr_after_rst", stat_wr_cnt, 32'd1);
    chk("stat_rd_after_rst", stat_rd_cnt, 32'd0);
    chk("stat_err_after_rst", stat_err_cnt, 32'd0);
`endif
    chk("exp_queue_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
